iob_ram_be_initiator: RTL and testbench

IOB_RAM_BE_INITIATOR -- requirements
Module: iob_ram_be_initiator

---
 rtl/iob_ram_be_initiator.sv | 76 +++++++
 tb/tb_iob_ram_be_initiator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ram_be_initiator.sv
// Purpose: valid/ready request front-end to a byte-enable RAM with a registered read port; read data is returned through a 2-entry response FIFO.
// Latency: a read accepted in cycle N gives rvalid_o in cycle N+2 when the FIFO is empty; writes are fire-and-forget and produce no response.
// Backpressure: writes are always accepted; reads stall while buffered plus in-flight responses would exceed the 2 FIFO slots.
module iob_ram_be_initiator #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ram_en_o,
  output logic [DATA_W/8-1:0] ram_wstrb_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_d_o,
  input  logic [DATA_W-1:0]   ram_d_i
);
  localparam int STRB_W = DATA_W / 8;

  logic              isWrite;
  logic              accept;
  logic              pop;
  logic              inflight;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic              wrPtr;
  logic              rdPtr;
  logic [DATA_W-1:0] respMem [2];

  assign isWrite   = |req_wstrb_i;
  assign rvalid_o  = (count != 2'd0);
  assign pop       = rvalid_o & rready_i;
  assign rdata_o   = respMem[rdPtr];

  // Occupancy counts the read already in the RAM pipe, so a newly accepted
  // read always finds a free slot when its data lands a cycle later.
  assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign req_ready_o = arst_n_i & (isWrite | (occupancy < 3'd2));
  assign accept      = req_valid_i & req_ready_o;

  assign ram_en_o    = accept;
  assign ram_wstrb_o = accept ? req_wstrb_i : {STRB_W{1'b0}};
  assign ram_addr_o  = req_addr_i;
  assign ram_d_o     = req_wdata_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      inflight   <= 1'b0;
      count      <= 2'd0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      respMem[0] <= '0;
      respMem[1] <= '0;
    end else begin
      inflight <= accept & ~isWrite;
      if (inflight) begin
        respMem[wrPtr] <= ram_d_i;
        wrPtr          <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_ram_be_initiator.sv
// Bench for iob_ram_be_initiator: byte-enable RAM model with 1-cycle registered read,
// reference memory plus response scoreboard, a vector table and hand-written corner sequences.
module tb_iob_ram_be_initiator;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] rdata;
  logic        ram_en;
  logic [3:0]  ram_wstrb;
  logic [3:0]  ram_addr;
  logic [31:0] ram_d;
  logic [31:0] ram_q = '0;

  iob_ram_be_initiator #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
    .ram_en_o(ram_en), .ram_wstrb_o(ram_wstrb), .ram_addr_o(ram_addr),
    .ram_d_o(ram_d), .ram_d_i(ram_q)
  );

  always #5 clk = ~clk;

  // RAM model: read-before-write, output register only loads on reads.
  logic [31:0] ramMem [16];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wstrb == 4'h0) ram_q <= ramMem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) ramMem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
    end
  end

  int nCmp = 0;
  int nErr = 0;
  int cyc = 0;
  int nReads = 0;
  int nResp = 0;
  logic [31:0] refMem [16];
  logic [31:0] sb [$];
  int accCycles [$];
  int popCycles [$];
  logic [31:0] lastData = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    nCmp++;
    nErr++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Response monitor: every handshake must match the oldest outstanding read.
  always @(negedge clk) begin
    if (arst_n && rvalid && rready) begin
      if (sb.size() == 0) begin
        timeoutFail("unexpectedResponse");
      end else begin
        chk("rdata", rdata, sb.pop_front());
      end
      popCycles.push_back(cyc);
      lastData = rdata;
      nResp++;
    end
  end

  // Called at the sampling point of an accepted request.
  task automatic record();
    logic [31:0] mask;
    if (req_wstrb == 4'h0) begin
      sb.push_back(refMem[req_addr]);
      accCycles.push_back(cyc);
      nReads++;
    end else begin
      mask = '0;
      for (int b = 0; b < 4; b++) if (req_wstrb[b]) mask[8*b +: 8] = 8'hFF;
      refMem[req_addr] = (refMem[req_addr] & ~mask) | (req_wdata & mask);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output int waits);
    bit done;
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    waits = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        record();
        done = 1;
      end else begin
        waits++;
        if (waits > 40) begin
          timeoutFail("issue");
          done = 1;
        end else begin
          tick();
        end
      end
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) timeoutFail("drain");
    tick();
  endtask

  task automatic chkLatency(input string name);
    chk({name, "Count"}, 32'(popCycles.size()), 32'(accCycles.size()));
    for (int i = 0; i < accCycles.size() && i < popCycles.size(); i++)
      chk(name, 32'(popCycles[i] - accCycles[i]), 32'd2);
  endtask

  typedef struct {
    logic        vld;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        expEn;
    logic [3:0]  expStrb;
    logic        expRdy;
  } vec_t;

  vec_t vecs [8];
  int w;

  initial begin
    vecs[0] = '{1'b1, 4'd10, 32'hDEADBEEF, 4'hF,    1'b1, 4'hF,    1'b1};
    vecs[1] = '{1'b0, 4'd11, 32'h12345678, 4'hF,    1'b0, 4'h0,    1'b1};
    vecs[2] = '{1'b1, 4'd10, 32'h00000000, 4'h0,    1'b1, 4'h0,    1'b1};
    vecs[3] = '{1'b1, 4'd11, 32'hCAFEF00D, 4'b1000, 1'b1, 4'b1000, 1'b1};
    vecs[4] = '{1'b0, 4'd11, 32'h00000000, 4'h0,    1'b0, 4'h0,    1'b1};
    vecs[5] = '{1'b1, 4'd11, 32'h00000000, 4'h0,    1'b1, 4'h0,    1'b1};
    vecs[6] = '{1'b1, 4'd12, 32'h000000A5, 4'b0001, 1'b1, 4'b0001, 1'b1};
    vecs[7] = '{1'b1, 4'd12, 32'h00000000, 4'h0,    1'b1, 4'h0,    1'b1};

    // Reset state, with a write presented to show the RAM port stays quiet.
    req_valid = 1'b1; req_wstrb = 4'hF;
    #12;
    chk("rstRamEn", ram_en, 1'b0);
    chk("rstRamWstrb", ram_wstrb, 4'h0);
    chk("rstRvalid", rvalid, 1'b0);
    chk("rstRdata", rdata, 32'h0);
    req_valid = 1'b0; req_wstrb = 4'h0;
    tick();
    arst_n = 1'b1;
    tick();

    // Fill memory, then stream 16 reads back-to-back.
    for (int i = 0; i < 16; i++) issue(4'(i), 32'(32 + i), 4'hF, w);
    accCycles.delete(); popCycles.delete();
    rready = 1'b1;
    req_valid = 1'b1; req_wstrb = 4'h0;
    for (int i = 0; i < 16; i++) begin
      req_addr = 4'(i);
      @(negedge clk);
      chk("streamReady", req_ready, 1'b1);
      if (req_ready) record();
      tick();
    end
    req_valid = 1'b0;
    drain();
    chkLatency("streamLatency");
    chk("streamLastData", lastData, 32'd47);

    // Partial byte-strobe write merges into existing word.
    issue(4'd3, 32'h11223344, 4'hF, w);
    issue(4'd3, 32'hAABBCCDD, 4'b0101, w);
    issue(4'd3, 32'h0, 4'h0, w);
    drain();
    chk("byteMerge", lastData, 32'h11BB33DD);

    // Combinational vector table with rready held high.
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].vld; req_addr = vecs[i].addr;
      req_wdata = vecs[i].wdata; req_wstrb = vecs[i].wstrb;
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), ram_en, vecs[i].expEn);
      chk($sformatf("vec%0d_wstrb", i), ram_wstrb, vecs[i].expStrb);
      chk($sformatf("vec%0d_rdy", i), req_ready, vecs[i].expRdy);
      chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].addr);
      chk($sformatf("vec%0d_d", i), ram_d, vecs[i].wdata);
      if (req_valid && req_ready) record();
      tick();
    end
    req_valid = 1'b0;
    drain();

    // Response backpressure: only two reads fit, head data holds still.
    rready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(4'(4 + i), 32'h0, 4'h0, w);
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bpReadyLow", req_ready, 1'b0);
          chk("bpRvalid", rvalid, 1'b1);
          chk("bpHeadStable", rdata, 32'd36);
        end
        tick();
        rready = 1'b1;
      end
    join
    drain();

    // FIFO full: a write still goes straight through.
    rready = 1'b0;
    issue(4'd1, 32'h0, 4'h0, w);
    issue(4'd2, 32'h0, 4'h0, w);
    repeat (2) tick();
    issue(4'd9, 32'h5A5A1234, 4'hF, w);
    chk("fullWriteNoWait", 32'(w), 32'd0);
    chk("fullRvalid", rvalid, 1'b1);
    rready = 1'b1;
    drain();
    issue(4'd9, 32'h0, 4'h0, w);
    drain();
    chk("fullWriteLanded", lastData, 32'h5A5A1234);
    chk("respCount", 32'(nResp), 32'(nReads));

    // Reset one cycle after a read is accepted.
    issue(4'd5, 32'h0, 4'h0, w);
    arst_n = 1'b0;
    #1;
    chk("midRstRvalid", rvalid, 1'b0);
    chk("midRstRdata", rdata, 32'h0);
    sb.delete(); accCycles.delete(); popCycles.delete();
    repeat (2) tick();
    arst_n = 1'b1;
    @(negedge clk);
    chk("postRstReady", req_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postRstQuiet", rvalid, 1'b0);
    end
    tick();
    issue(4'd6, 32'h0, 4'h0, w);
    drain();
    chkLatency("postRstLatency");
    chk("postRstData", lastData, 32'd38);

    // Alternating read/write every cycle, no stalls.
    accCycles.delete(); popCycles.delete();
    rready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 4'(i); req_wstrb = 4'h0;
      @(negedge clk);
      chk("altReadReady", req_ready, 1'b1);
      if (req_ready) record();
      tick();
      req_addr = 4'(8 + i); req_wdata = 32'hA000_0000 + 32'(i); req_wstrb = 4'hF;
      @(negedge clk);
      chk("altWriteReady", req_ready, 1'b1);
      if (req_ready) record();
      tick();
    end
    req_valid = 1'b0; req_wstrb = 4'h0;
    drain();
    chkLatency("altLatency");
    for (int i = 0; i < 2; i++) begin
      issue(4'(8 + i), 32'h0, 4'h0, w);
    end
    drain();
    chk("altWriteLanded", lastData, 32'hA000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
